wb_forward_unit: RTL

//  Back end of the register-file interface: carries each issued instruction's destination

---
 rtl/wb_forward_unit_if.sv | 41 ++++
 rtl/wb_forward_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/wb_forward_unit_if.sv
// rtl/wb_forward_unit_if.sv - EX/decode/regfile signal bundle for the write-back and forwarding unit
interface wb_forward_unit_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
);
    logic              ex_valid;
    logic              ex_regwrite;
    logic              ex_memtoreg;
    logic              ex_link;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] ex_next_pc;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_W-1:0]  id_rn;
    logic [REG_W-1:0]  id_rr2;
    logic              id_rn_used;
    logic              id_rr2_used;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd2_data;
    logic              stall;
    logic              RegWrite;
    logic [REG_W-1:0]  WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [31:0]       retired;

    modport master (
        output ex_valid, ex_regwrite, ex_memtoreg, ex_link, ex_rd, ex_result, ex_next_pc,
        output mem_rdata, id_rn, id_rr2, id_rn_used, id_rr2_used,
        input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, stall,
        input  RegWrite, WriteRegister, WriteData, retired
    );

    modport slave (
        input  ex_valid, ex_regwrite, ex_memtoreg, ex_link, ex_rd, ex_result, ex_next_pc,
        input  mem_rdata, id_rn, id_rr2, id_rn_used, id_rr2_used,
        output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, stall,
        output RegWrite, WriteRegister, WriteData, retired
    );
endinterface

// File: rtl/wb_forward_unit.sv
// rtl/wb_forward_unit.sv - MEM/WB pipeline registers, regfile write port, bypass, load-use stall, retire count
module wb_forward_unit #(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int LINK_REG = 30
) (
    input logic          clk,
    input logic          rst,
    wb_forward_unit_if.slave bus
);
    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
    localparam logic [REG_W-1:0] LR = REG_W'(LINK_REG);

    // EX stage view
    logic [REG_W-1:0]  ex_dest;
    logic              ex_we;
    logic              ex_fwd_ok;
    logic [DATA_W-1:0] ex_value;

    // MEM stage register
    logic              mem_valid;
    logic              mem_regwrite;
    logic              mem_memtoreg;
    logic              mem_link;
    logic [REG_W-1:0]  mem_dest;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] mem_next_pc;
    logic              mem_we;
    logic [DATA_W-1:0] mem_value;

    // WB stage register
    logic              wb_valid;
    logic              wb_we;
    logic [REG_W-1:0]  wb_dest;
    logic [DATA_W-1:0] wb_data;

    logic [31:0]       retired_q;

    assign ex_dest   = bus.ex_link ? LR : bus.ex_rd;
    assign ex_we     = bus.ex_valid & bus.ex_regwrite & (ex_dest != ZR);
    // A load's data does not exist yet in EX; it is served from MEM one cycle later.
    assign ex_fwd_ok = ex_we & ~bus.ex_memtoreg;
    assign ex_value  = bus.ex_link ? bus.ex_next_pc : bus.ex_result;

    assign mem_we    = mem_valid & mem_regwrite & (mem_dest != ZR);
    assign mem_value = mem_memtoreg ? bus.mem_rdata :
                       mem_link     ? mem_next_pc   : mem_result;

    // Capture the EX instruction into MEM every cycle; stall never freezes this pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_link     <= 1'b0;
            mem_dest     <= '0;
            mem_result   <= '0;
            mem_next_pc  <= '0;
        end else begin
            mem_valid    <= bus.ex_valid;
            mem_regwrite <= bus.ex_regwrite;
            mem_memtoreg <= bus.ex_memtoreg;
            mem_link     <= bus.ex_link;
            mem_dest     <= ex_dest;
            mem_result   <= bus.ex_result;
            mem_next_pc  <= bus.ex_next_pc;
        end
    end

    // Capture the resolved MEM value and effective write into WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= mem_valid;
            wb_we    <= mem_we;
            wb_dest  <= mem_dest;
            wb_data  <= mem_value;
        end
    end

    // Count every real instruction leaving WB, whether or not it writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (wb_valid) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.RegWrite      = wb_we;
    assign bus.WriteRegister = wb_dest;
    assign bus.WriteData     = wb_data;
    assign bus.retired       = retired_q;

    // Youngest producer wins: EX, then MEM, then WB; returns {hit, data}
    function automatic logic [DATA_W:0] fwd_pick(
        input logic              used,
        input logic [REG_W-1:0]  addr,
        input logic              e_ok,
        input logic [REG_W-1:0]  e_dest,
        input logic [DATA_W-1:0] e_val,
        input logic              m_ok,
        input logic [REG_W-1:0]  m_dest,
        input logic [DATA_W-1:0] m_val,
        input logic              w_ok,
        input logic [REG_W-1:0]  w_dest,
        input logic [DATA_W-1:0] w_val
    );
        logic [DATA_W:0] r;
        r = '0;
        if (used && addr != ZR) begin
            if (e_ok && e_dest == addr)      r = {1'b1, e_val};
            else if (m_ok && m_dest == addr) r = {1'b1, m_val};
            else if (w_ok && w_dest == addr) r = {1'b1, w_val};
        end
        return r;
    endfunction

    assign {bus.fwd1_hit, bus.fwd1_data} = fwd_pick(bus.id_rn_used, bus.id_rn,
        ex_fwd_ok, ex_dest, ex_value, mem_we, mem_dest, mem_value, wb_we, wb_dest, wb_data);
    assign {bus.fwd2_hit, bus.fwd2_data} = fwd_pick(bus.id_rr2_used, bus.id_rr2,
        ex_fwd_ok, ex_dest, ex_value, mem_we, mem_dest, mem_value, wb_we, wb_dest, wb_data);

    assign bus.stall = bus.ex_valid & bus.ex_regwrite & bus.ex_memtoreg & (bus.ex_rd != ZR) &
                       ((bus.id_rn_used  & (bus.id_rn  == bus.ex_rd)) |
                        (bus.id_rr2_used & (bus.id_rr2 == bus.ex_rd)));
endmodule
